// File: rtl/contador_pkg.sv
// contador_pkg: shared state encoding and default widths for the contador sequencer
package contador_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_PASS_W = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, UP, DOWN, DONE} state_t;
endpackage

// File: rtl/contador_seq_check.sv
// contador_seq_check: shadow of the expected counter value; mis flags divergence of cnt_q in UP/DOWN
// ports: clk, rst (sync high); st controller state; cnt_q observed counter; mis mismatch flag
module contador_seq_check import contador_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           st,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             mis
);
  logic [WIDTH-1:0] ex;
  logic run;
  assign run = st == UP || st == DOWN;
  always_ff @(posedge clk)
    ex <= (rst || !run) ? '0 : st == UP ? ex + WIDTH'(1) : ex - WIDTH'(1);
  assign mis = run && cnt_q != ex;
endmodule

// File: rtl/contador_sequenciador.sv
// contador_sequenciador: drives the contador counter through target-high ping-pong sweeps
// ports: clk, rst (sync high); start/target/passes host command; cnt_q counter value;
//   cnt_rst/cnt_w counter drive; busy/done/err status; pass_cnt completed passes.
// CONTADOR_SEQ_CHECK_EN adds an expected-value tracker that aborts the run on divergence.
module contador_sequenciador import contador_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  target,
  input  logic [PASS_W-1:0] passes,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              cnt_rst,
  output logic              cnt_w,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);
  state_t st;
  logic [WIDTH-1:0] tgt;
  logic [PASS_W-1:0] npas, pnext;
  logic mis;
  assign pnext = pass_cnt + PASS_W'(1);
`ifdef CONTADOR_SEQ_CHECK_EN
  contador_seq_check #(.WIDTH(WIDTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .st    (st),
    .cnt_q (cnt_q),
    .mis   (mis)
  );
`else
  assign mis = 1'b0;
`endif
  // decisions look at pre-edge cnt_q so the turn happens on the edge that reaches the peak or 0
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt_rst  <= 1'b1;
      cnt_w    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
      tgt      <= '0;
      npas     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (mis) begin
        st      <= IDLE;
        cnt_rst <= 1'b1;
        cnt_w   <= 1'b0;
        busy    <= 1'b0;
        err     <= 1'b1;
      end else begin
        case (st)
          IDLE:
            if (start) begin
              if (target != '0 && passes != '0) begin
                tgt      <= target;
                npas     <= passes;
                pass_cnt <= '0;
                busy     <= 1'b1;
                st       <= CLEAR;
              end else err <= 1'b1;
            end
          CLEAR: begin
            st      <= UP;
            cnt_rst <= 1'b0;
            cnt_w   <= 1'b1;
          end
          UP:
            if (cnt_q == tgt - WIDTH'(1)) begin
              st    <= DOWN;
              cnt_w <= 1'b0;
            end
          DOWN:
            if (cnt_q == WIDTH'(1)) begin
              pass_cnt <= pnext;
              if (pnext == npas) begin
                st      <= DONE;
                cnt_rst <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                st    <= UP;
                cnt_w <= 1'b1;
              end
            end
          DONE: st <= IDLE;
          default: begin
            st      <= IDLE;
            cnt_rst <= 1'b1;
            cnt_w   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
